// File: rtl/lc3b_types.sv
// Shared types for the branch-resolve slice: machine word, resolver state and
// the in-flight prediction record carried from fetch to resolve.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } branch_resolve_state_t;

  typedef struct packed {
    lc3b_word pc;
    logic     hit;
    lc3b_word target;
  } pred_entry_t;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic lc3b_word sat_inc(input lc3b_word v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/pred_fifo.sv
// In-flight prediction FIFO. Push and pop are pre-qualified by the caller;
// clear wins over everything, including a push in the same cycle.
module pred_fifo
  import lc3b_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        push,
  input  logic        pop,
  input  pred_entry_t din,
  output pred_entry_t dout,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  pred_entry_t   mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
  assign dout  = mem_q[rd_q];

  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (clear) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_pop)  rd_d = rd_q + 1'b1;
      if (do_push) wr_d = wr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the counters alone define which slots are live.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/branch_resolve.sv
// Compares each resolving instruction against the prediction made at fetch,
// requests a flush/redirect and BTB update on mismatch, then holds in RECOVER.
module branch_resolve
  import lc3b_types::*;
#(
  parameter int DEPTH          = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pred_valid,
  input  lc3b_word              pred_pc,
  input  logic                  pred_hit,
  input  lc3b_word              pred_target,
  input  logic                  stall,
  input  logic                  res_valid,
  input  logic                  res_branch,
  input  logic                  res_taken,
  input  lc3b_word              res_target,
  output logic                  btb_load,
  output lc3b_word              btb_pc_store,
  output lc3b_word              btb_instr_addr,
  output logic                  mispredict,
  output lc3b_word              redirect_pc,
  output logic                  busy,
  output lc3b_word              branch_count,
  output lc3b_word              mispredict_count,
  output logic                  overflow,
  output logic                  underflow,
  output branch_resolve_state_t state_dbg
);

  localparam logic [2:0] RC_LOAD = 3'(RECOVER_CYCLES - 1);

  branch_resolve_state_t state_q, state_d;
  logic [2:0]  rc_q, rc_d;
  logic        run, push_req, pop_req, push, pop;
  logic        fifo_full, fifo_empty;
  logic        taken_br, mp_taken, mp_nt, mp;
  pred_entry_t head, pred_in;

  logic     btb_load_q, mispredict_q, overflow_q, underflow_q;
  lc3b_word btb_pc_store_q, btb_instr_addr_q, redirect_pc_q;
  lc3b_word branch_count_q, mispredict_count_q;

  assign pred_in = '{pc: pred_pc, hit: pred_hit, target: pred_target};

  pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (mp),
    .push  (push),
    .pop   (pop),
    .din   (pred_in),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    run      = (state_q == ST_RUN);
    push_req = pred_valid & ~stall & run;
    pop_req  = res_valid & ~stall & run;
    pop      = pop_req & ~fifo_empty;
    push     = push_req & (~fifo_full | pop);
    taken_br = res_branch & res_taken;
    mp_taken = pop & taken_br & (~head.hit | (head.target != res_target));
    mp_nt    = pop & head.hit & ~taken_br;
    mp       = mp_taken | mp_nt;
  end

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    case (state_q)
      ST_RUN: begin
        if (mp) begin
          state_d = ST_RECOVER;
          rc_d    = RC_LOAD;
        end
      end
      ST_RECOVER: begin
        if (rc_q == 3'd0) state_d = ST_RUN;
        else              rc_d    = rc_q - 3'd1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= ST_RUN;
      rc_q               <= '0;
      btb_load_q         <= 1'b0;
      mispredict_q       <= 1'b0;
      btb_pc_store_q     <= '0;
      btb_instr_addr_q   <= '0;
      redirect_pc_q      <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
      overflow_q         <= 1'b0;
      underflow_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      rc_q             <= rc_d;
      mispredict_q     <= mp;
      btb_load_q       <= mp_taken;
      btb_pc_store_q   <= mp_taken ? head.pc : '0;
      btb_instr_addr_q <= mp_taken ? res_target : '0;
      // Not-taken recovery falls through to the next sequential LC-3b word.
      redirect_pc_q    <= mp_taken ? res_target : (mp_nt ? head.pc + 16'd2 : '0);
      branch_count_q     <= sat_inc(branch_count_q, pop & res_branch);
      mispredict_count_q <= sat_inc(mispredict_count_q, mp);
      overflow_q  <= overflow_q | (push_req & fifo_full & ~pop);
      underflow_q <= underflow_q | (pop_req & fifo_empty);
    end
  end

  assign btb_load         = btb_load_q;
  assign btb_pc_store     = btb_pc_store_q;
  assign btb_instr_addr   = btb_instr_addr_q;
  assign mispredict       = mispredict_q;
  assign redirect_pc      = redirect_pc_q;
  assign busy             = (state_q == ST_RECOVER);
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
  assign overflow         = overflow_q;
  assign underflow        = underflow_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed scenarios then random traffic, every
// cycle compared against a queue-based behavioural model.
module tb_branch_resolve;
  import lc3b_types::*;

  localparam int DEPTH = 4;
  localparam int RC    = 2;

  logic clk = 1'b0;
  logic reset;
  logic pred_valid, pred_hit, stall, res_valid, res_branch, res_taken;
  logic [15:0] pred_pc, pred_target, res_target;
  logic btb_load, mispredict, busy, overflow, underflow;
  logic [15:0] btb_pc_store, btb_instr_addr, redirect_pc, branch_count, mispredict_count;
  branch_resolve_state_t state_dbg;

  branch_resolve #(.DEPTH(DEPTH), .RECOVER_CYCLES(RC)) dut (
    .clk              (clk),
    .reset            (reset),
    .pred_valid       (pred_valid),
    .pred_pc          (pred_pc),
    .pred_hit         (pred_hit),
    .pred_target      (pred_target),
    .stall            (stall),
    .res_valid        (res_valid),
    .res_branch       (res_branch),
    .res_taken        (res_taken),
    .res_target       (res_target),
    .btb_load         (btb_load),
    .btb_pc_store     (btb_pc_store),
    .btb_instr_addr   (btb_instr_addr),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .busy             (busy),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count),
    .overflow         (overflow),
    .underflow        (underflow),
    .state_dbg        (state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // reference model: in-flight predictions as a plain queue
  typedef struct {
    logic [15:0] pc;
    logic        hit;
    logic [15:0] tgt;
  } ent_t;
  ent_t exp_q[$];
  int   rec_left;
  logic e_mp, e_load, e_busy, e_ovf, e_unf;
  logic [15:0] e_redir, e_store, e_iaddr, e_bc, e_mc;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    rec_left = 0;
    e_mp = 0; e_load = 0; e_busy = 0; e_ovf = 0; e_unf = 0;
    e_redir = 0; e_store = 0; e_iaddr = 0; e_bc = 0; e_mc = 0;
  endtask

  task automatic model_step();
    ent_t h;
    bit   mp_t, mp_n, flush;
    flush = 0;
    e_mp = 0; e_load = 0; e_redir = 0; e_store = 0; e_iaddr = 0;
    if (rec_left > 0) begin
      rec_left--;
    end else begin
      if (res_valid && !stall) begin
        if (exp_q.size() == 0) e_unf = 1;
        else begin
          h = exp_q.pop_front();
          if (res_branch && e_bc != 16'hFFFF) e_bc++;
          mp_t = res_branch && res_taken && (!h.hit || h.tgt != res_target);
          mp_n = h.hit && !(res_branch && res_taken);
          if (mp_t) begin
            e_mp = 1; e_load = 1; e_redir = res_target; e_store = h.pc; e_iaddr = res_target;
          end else if (mp_n) begin
            e_mp = 1; e_redir = h.pc + 16'd2;
          end
          if (mp_t || mp_n) begin
            flush = 1;
            if (e_mc != 16'hFFFF) e_mc++;
          end
        end
      end
      if (pred_valid && !stall) begin
        if (exp_q.size() >= DEPTH) e_ovf = 1;
        else exp_q.push_back('{pred_pc, pred_hit, pred_target});
      end
      if (flush) begin
        exp_q.delete();
        rec_left = RC;
      end
    end
    e_busy = (rec_left > 0);
  endtask

  task automatic check_all();
    check_eq("mispredict", 16'(mispredict), 16'(e_mp));
    check_eq("btb_load", 16'(btb_load), 16'(e_load));
    check_eq("redirect_pc", redirect_pc, e_redir);
    check_eq("btb_pc_store", btb_pc_store, e_store);
    check_eq("btb_instr_addr", btb_instr_addr, e_iaddr);
    check_eq("busy", 16'(busy), 16'(e_busy));
    check_eq("state", 16'(state_dbg), e_busy ? 16'(ST_RECOVER) : 16'(ST_RUN));
    check_eq("branch_count", branch_count, e_bc);
    check_eq("mispredict_count", mispredict_count, e_mc);
    check_eq("overflow", 16'(overflow), 16'(e_ovf));
    check_eq("underflow", 16'(underflow), 16'(e_unf));
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic apply(input logic pv, input logic [15:0] pc, input logic hit,
                       input logic [15:0] tgt, input logic st, input logic rv,
                       input logic rb, input logic rt, input logic [15:0] rtgt);
    pred_valid = pv; pred_pc = pc; pred_hit = hit; pred_target = tgt;
    stall = st; res_valid = rv; res_branch = rb; res_taken = rt; res_target = rtgt;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(0, 16'h0, 0, 16'h0, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic push(input logic [15:0] pc, input logic hit, input logic [15:0] tgt);
    apply(1, pc, hit, tgt, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic do_reset();
    pred_valid = 0; pred_pc = 0; pred_hit = 0; pred_target = 0;
    stall = 0; res_valid = 0; res_branch = 0; res_taken = 0; res_target = 0;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();

    // hit=0, taken branch: taken-mispredict with BTB write
    push(16'h0040, 0, 16'h0000);
    apply(0, 16'h0, 0, 16'h0, 0, 1, 1, 1, 16'h0080);
    idle(3);

    // correct taken prediction
    do_reset();
    push(16'h0100, 1, 16'h0120);
    apply(0, 16'h0, 0, 16'h0, 0, 1, 1, 1, 16'h0120);
    idle(1);

    // predicted taken at top of memory, resolves not taken: redirect wraps
    do_reset();
    push(16'hFFFE, 1, 16'h1234);
    apply(0, 16'h0, 0, 16'h0, 0, 1, 1, 0, 16'h0000);
    idle(3);

    // fill past depth, then drain past empty
    do_reset();
    for (int i = 0; i < 5; i++) push(16'(16'h0200 + 2 * i), 0, 16'h0);
    for (int i = 0; i < 5; i++) apply(0, 16'h0, 0, 16'h0, 0, 1, 0, 0, 16'h0);
    idle(1);

    // mispredict with younger entries and a simultaneous push: all flushed
    do_reset();
    push(16'h0300, 0, 16'h0);
    push(16'h0302, 0, 16'h0);
    push(16'h0304, 1, 16'h0400);
    push(16'h0306, 0, 16'h0);
    apply(1, 16'h0308, 0, 16'h0, 0, 1, 1, 1, 16'h0500);
    idle(3);
    apply(0, 16'h0, 0, 16'h0, 0, 1, 1, 1, 16'h0500);
    idle(1);

    // asynchronous reset while recovering, with the mispredict pulse live
    do_reset();
    push(16'h0600, 0, 16'h0);
    apply(0, 16'h0, 0, 16'h0, 0, 1, 1, 1, 16'h0700);
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // random traffic, including stalls during RUN and RECOVER
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] pc;
      pc = ($urandom_range(0, 15) == 0) ? 16'hFFFE : 16'($urandom);
      apply(1'($urandom_range(0, 1)), pc, 1'($urandom_range(0, 1)),
            16'($urandom_range(0, 3)) << 4,
            ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 19) < 9),
            ($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 1)),
            16'($urandom_range(0, 3)) << 4);
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
